// File: rtl/mips_mem_pkg.sv
// Shared definitions for the multicycle MIPS memory responder.
// Covers the FSM encoding, the word geometry and the wait-counter width.
package mips_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_CNT_W = 4;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/mips_word_ram.sv
// Single-port word array with synchronous read and write.
// The read register clears on reset; the array contents never do.
module mips_word_ram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // rdata only moves on a read, so it holds across writes and rejected accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder: latches a strobe, waits WAIT_CYCLES, then completes
// the access with a one-cycle mem_ready pulse and an error flag.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              addr_err
);

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [1:0]        state;
  wait_cnt_t         wait_cnt;
  logic              op_write_q;
  logic              op_err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;

  logic              req;
  logic              req_err;
  logic              go_now;
  logic              go_wait;
  logic              acc_go;
  logic              acc_write;
  logic              acc_err;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_data;
  logic              ram_we;
  logic              ram_re;

  assign req     = mem_read | mem_write;
  assign req_err = (mem_read & mem_write)
                 | (addr[OFF_W-1:0] != '0)
                 | ((addr >> (IDX_W + OFF_W)) != '0);

  // The array is touched on the edge that enters RESP, so read_data lands
  // in the same cycle as mem_ready. With no wait states that edge is the
  // request edge itself and the live inputs stand in for the latched copy.
  assign go_now  = (state == ST_IDLE) && req && (WAIT_CYCLES == 0);
  assign go_wait = (state == ST_WAIT) && (wait_cnt == '0);
  assign acc_go  = go_now | go_wait;

  assign acc_write = go_now ? mem_write  : op_write_q;
  assign acc_err   = go_now ? req_err    : op_err_q;
  assign acc_idx   = go_now ? addr[IDX_W+OFF_W-1:OFF_W] : idx_q;
  assign acc_data  = go_now ? write_data : data_q;

  assign ram_we = rst & acc_go & ~acc_err & acc_write;
  assign ram_re = rst & acc_go & ~acc_err & ~acc_write;

  mips_word_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (acc_idx),
    .wdata (acc_data),
    .rdata (read_data)
  );

  // Request decode happens once at latch time; WAIT ignores the bus entirely.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      mem_ready  <= 1'b0;
      mem_busy   <= 1'b0;
      addr_err   <= 1'b0;
      op_write_q <= 1'b0;
      op_err_q   <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
    end else begin
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_write_q <= mem_write;
            op_err_q   <= req_err;
            idx_q      <= addr[IDX_W+OFF_W-1:OFF_W];
            data_q     <= write_data;
            mem_busy   <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES - 1);
              state    <= ST_WAIT;
            end else begin
              mem_ready <= 1'b1;
              addr_err  <= req_err;
              state     <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            mem_ready <= 1'b1;
            addr_err  <= op_err_q;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          mem_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          mem_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench: one responder with two wait states and one
// with none, both compared against a word-array reference model.
module tb_mips_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    mem_read;
  logic [1:0]    mem_write;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] write_data [2];
  logic [DW-1:0] read_data [2];
  logic [1:0]    mem_ready;
  logic [1:0]    mem_busy;
  logic [1:0]    addr_err;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] mdl [2][DEPTH];
  bit            known [2][DEPTH];
  logic [DW-1:0] expRd [2];
  bit            expRdKnown [2];

  mips_mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .addr(addr[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .mem_ready(mem_ready[0]), .mem_busy(mem_busy[0]), .addr_err(addr_err[0])
  );

  mips_mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .addr(addr[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .mem_ready(mem_ready[1]), .mem_busy(mem_busy[1]), .addr_err(addr_err[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete handshake on responder d; the model decides what must happen.
  task automatic applyStimulus(input int d, input bit r, input bit w,
                               input logic [AW-1:0] a, input logic [DW-1:0] data,
                               input bit scramble);
    int  waits;
    int  n;
    int  idx;
    bit  err;
    bit  done;
    waits = (d == 0) ? 2 : 0;
    err   = (r && w) || (a % 4 != 0) || (a >= 4 * DEPTH);
    idx   = (a / 4) % DEPTH;
    @(negedge clk);
    mem_read[d]   = r;
    mem_write[d]  = w;
    addr[d]       = a;
    write_data[d] = data;
    n    = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && scramble) begin
        addr[d]       = a ^ 32'h4;
        write_data[d] = ~data;
      end
      checkOutput("busy_in_flight", mem_busy[d], 1);
      if (mem_ready[d]) done = 1;
    end
    checkOutput("latency", n, waits + 1);
    checkOutput("addr_err", addr_err[d], err);
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    if (!err && w) begin
      mdl[d][idx]   = data;
      known[d][idx] = 1'b1;
    end
    if (!err && r) begin
      expRd[d]      = mdl[d][idx];
      expRdKnown[d] = known[d][idx];
    end
    if (expRdKnown[d]) checkOutput("read_data", read_data[d], expRd[d]);
    @(posedge clk);
    #1;
    checkOutput("ready_one_cycle", mem_ready[d], 0);
    checkOutput("busy_drop", mem_busy[d], 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind;
    int idx;
    bit r;
    bit w;
    logic [AW-1:0] a;

    for (int d = 0; d < 2; d++) begin
      mem_read[d] = 1'b0; mem_write[d] = 1'b0; addr[d] = '0; write_data[d] = '0;
      expRd[d] = '0; expRdKnown[d] = 1'b1;
    end

    // Reset held with a read strobe asserted must not start anything.
    rst = 1'b0;
    mem_read = 2'b11;
    addr[0] = 32'h10;
    addr[1] = 32'h10;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("rst_ready", mem_ready[0], 0);
      checkOutput("rst_busy", mem_busy[0], 0);
      checkOutput("rst_rdata", read_data[0], 0);
      checkOutput("rst_err", addr_err[0], 0);
      checkOutput("rst_ready0", mem_ready[1], 0);
    end
    @(negedge clk);
    mem_read = 2'b00;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_busy", mem_busy[0], 0);
      checkOutput("post_rst_ready", mem_ready[0], 0);
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        applyStimulus(d, 0, 1, 32'(i * 4), $urandom, 0);

    applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 0);
    applyStimulus(0, 0, 1, 32'h13, 32'hFFFFFFFF, 0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h00001000, 32'h0, 0);
    applyStimulus(0, 1, 1, 32'h10, 32'h0BAD0BAD, 0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 0);
    checkOutput("dir_deadbeef", read_data[0], 32'hDEADBEEF);
    applyStimulus(0, 0, 1, 32'h10, 32'h11112222, 1);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 0);
    checkOutput("dir_latched", read_data[0], 32'h11112222);
    applyStimulus(0, 1, 0, 32'h14, 32'h0, 0);

    applyStimulus(1, 0, 1, 32'h4, 32'h12345678, 0);
    applyStimulus(1, 1, 0, 32'h4, 32'h0, 0);
    checkOutput("w0_rdata", read_data[1], 32'h12345678);

    // Abort a write to 0x20 while it sits in WAIT.
    @(negedge clk);
    mem_write[0] = 1'b1;
    addr[0] = 32'h20;
    write_data[0] = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", mem_busy[0], 1);
    @(negedge clk);
    rst = 1'b0;
    mem_write[0] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_ready", mem_ready[0], 0);
    checkOutput("abort_busy_clr", mem_busy[0], 0);
    checkOutput("abort_rdata", read_data[0], 0);
    @(negedge clk);
    rst = 1'b1;
    expRd[0] = '0; expRdKnown[0] = 1'b1;
    expRd[1] = '0; expRdKnown[1] = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_ready", mem_ready[0], 0);
    end
    applyStimulus(0, 1, 0, 32'h20, 32'h0, 0);

    // Random mix of good accesses, misaligned, out-of-range and dual strobes.
    for (int t = 0; t < 360; t++) begin
      int d;
      d    = (t % 6 == 5) ? 1 : 0;
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 63);
      a    = 32'(idx * 4);
      r    = $urandom_range(0, 1);
      w    = !r;
      if (kind == 7) a = a | 32'($urandom_range(1, 3));
      if (kind == 8) a = a | (32'h1 << $urandom_range(12, 31));
      if (kind == 9) begin r = 1'b1; w = 1'b1; end
      applyStimulus(d, r, w, a, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
